// File: rtl/vram_access_arbiter.sv
// vram_access_arbiter: shares one single-port VRAM between the VGA pixel-fetch
// path (absolute priority) and two game-side clients served round-robin.
// Optional feature macro: VRAM_BLANK_ONLY_EN -- when defined, clients may only
// access the VRAM during blanking; when undefined, clients may use any cycle
// the display leaves free.
module vram_access_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 12,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vid_blank,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic [DATA_W-1:0]   disp_rdata,
  output logic                disp_rvalid,
  input  logic [1:0]          cli_req,
  input  logic [1:0]          cli_we,
  input  logic [2*ADDR_W-1:0] cli_addr,
  input  logic [2*DATA_W-1:0] cli_wdata,
  output logic [1:0]          cli_gnt,
  output logic [DATA_W-1:0]   cli_rdata,
  output logic [1:0]          cli_rvalid,
  output logic [1:0]          starve,
  input  logic                starve_clr,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Read-return tags: which requester a read in flight belongs to.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_CLI0 = 2'd2;
  localparam logic [1:0] TAG_CLI1 = 2'd3;

  // State = who owns the VRAM port in the current cycle.
  typedef enum logic [1:0] {IDLE, DISP, CLI0, CLI1} owner_t;

  owner_t              state, state_nxt;
  logic                rr_ptr;
  logic [1:0]          elig;
  logic [1:0]          gnt_sel;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [1:0]          rd_tag_p0;
  logic [1:0]          tag_pn [RD_LAT];
  logic [1:0]          ret_tag;
  logic [DATA_W-1:0]   disp_hold;
  logic [DATA_W-1:0]   cli_hold;
  logic [CNT_W-1:0]    wait_cnt [2];

  // Client eligibility: display always pre-empts; optionally blanking-only.
`ifdef VRAM_BLANK_ONLY_EN
  assign elig = cli_req & {2{~disp_req & vid_blank}};
`else
  logic unused_blank;
  assign unused_blank = vid_blank;
  assign elig = cli_req & {2{~disp_req}};
`endif

  // Next owner: display first, then round-robin between eligible clients.
  always_comb begin
    state_nxt = IDLE;
    gnt_sel   = 2'b00;
    if (disp_req) begin
      state_nxt = DISP;
    end else if (elig[0] && (!elig[1] || !rr_ptr)) begin
      state_nxt = CLI0;
      gnt_sel   = 2'b01;
    end else if (elig[1]) begin
      state_nxt = CLI1;
      gnt_sel   = 2'b10;
    end
  end

  // Grant is a same-cycle pulse; forced low while reset is held.
  assign cli_gnt = rst_n ? gnt_sel : 2'b00;

  // Select the access fields of the chosen owner.
  always_comb begin
    acc_we    = 1'b0;
    acc_addr  = disp_addr;
    acc_wdata = '0;
    case (state_nxt)
      CLI0: begin
        acc_we    = cli_we[0];
        acc_addr  = cli_addr[0 +: ADDR_W];
        acc_wdata = cli_wdata[0 +: DATA_W];
      end
      CLI1: begin
        acc_we    = cli_we[1];
        acc_addr  = cli_addr[ADDR_W +: ADDR_W];
        acc_wdata = cli_wdata[DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // Owner register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_sel[0])
        rr_ptr <= 1'b1;
      else if (gnt_sel[1])
        rr_ptr <= 1'b0;
    end
  end

  // Registered VRAM port; address/data only move when an access is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= (state_nxt != IDLE);
      mem_we <= acc_we;
      if (state_nxt != IDLE) begin
        mem_addr  <= acc_addr;
        mem_wdata <= acc_wdata;
      end
    end
  end

  // Tag of the read currently presented to the VRAM (writes carry no tag).
  always_comb begin
    rd_tag_p0 = TAG_NONE;
    case (state)
      DISP:    rd_tag_p0 = TAG_DISP;
      CLI0:    rd_tag_p0 = mem_we ? TAG_NONE : TAG_CLI0;
      CLI1:    rd_tag_p0 = mem_we ? TAG_NONE : TAG_CLI1;
      default: rd_tag_p0 = TAG_NONE;
    endcase
  end

  // Tag pipeline matching the VRAM read latency; reset drops reads in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) tag_pn[k] <= TAG_NONE;
    end else begin
      tag_pn[0] <= rd_tag_p0;
      for (int k = 1; k < RD_LAT; k++) tag_pn[k] <= tag_pn[k-1];
    end
  end

  assign ret_tag     = tag_pn[RD_LAT-1];
  assign disp_rvalid = (ret_tag == TAG_DISP);
  assign cli_rvalid  = {ret_tag == TAG_CLI1, ret_tag == TAG_CLI0};
  assign disp_rdata  = disp_rvalid ? mem_rdata : disp_hold;
  assign cli_rdata   = (|cli_rvalid) ? mem_rdata : cli_hold;

  // Keep the last returned word so the read buses hold between returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_hold <= '0;
      cli_hold  <= '0;
    end else begin
      if (disp_rvalid) disp_hold <= mem_rdata;
      if (|cli_rvalid) cli_hold  <= mem_rdata;
    end
  end

  // Per-client wait counters and sticky starvation flags; clear wins over set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) wait_cnt[i] <= '0;
      starve <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (starve_clr) begin
          wait_cnt[i] <= '0;
          starve[i]   <= 1'b0;
        end else if (!cli_req[i] || gnt_sel[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_ONE;
          if (wait_cnt[i] == CNT_MAX - CNT_ONE) starve[i] <= 1'b1;
        end
      end
    end
  end

endmodule
